// File: rtl/mux_arb_pkg.sv
// Shared types and default sizes for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ  = 32;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = mux_arb_pkg::N_REQ,
  parameter int unsigned SEL_W = mux_arb_pkg::SEL_W
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = SEL_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter/sequencer driving a 32:1 mux select and capturing its output.
// Optional grant counter output enabled by defining MUX_ARB_CNT_EN.
module mux32_rr_arbiter #(
  parameter int unsigned N_REQ  = mux_arb_pkg::N_REQ,
  parameter int unsigned DATA_W = mux_arb_pkg::DATA_W,
  parameter int unsigned SEL_W  = mux_arb_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] mux_data,
  output logic [SEL_W-1:0]  sel,
  output logic [N_REQ-1:0]  ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef MUX_ARB_CNT_EN
  ,
  output logic [mux_arb_pkg::CNT_W-1:0] grant_count
`endif
);

  import mux_arb_pkg::*;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_d;
  logic [N_REQ-1:0]  ack_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d;
  logic              busy_d;
  logic [SEL_W-1:0]  winner;
  logic              found;
`ifdef MUX_ARB_CNT_EN
  logic [CNT_W-1:0]  cnt_d;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and next register values; ack is a single-cycle pulse so it defaults low.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel;
    ack_d       = '0;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    ptr_d       = ptr_q;
`ifdef MUX_ARB_CNT_EN
    cnt_d       = grant_count;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          state_d = CAPT;
        end
      end
      CAPT: begin
        out_data_d  = mux_data;
        out_valid_d = 1'b1;
        ack_d       = N_REQ'(1) << sel;
        ptr_d       = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
        state_d     = HOLD;
`ifdef MUX_ARB_CNT_EN
        cnt_d       = grant_count + 1'b1;
`endif
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      ack       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ptr_q     <= '0;
`ifdef MUX_ARB_CNT_EN
      grant_count <= '0;
`endif
    end else begin
      sel       <= sel_d;
      ack       <= ack_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
      ptr_q     <= ptr_d;
`ifdef MUX_ARB_CNT_EN
      grant_count <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed self-checking bench for mux32_rr_arbiter with a behavioural 32:1 mux.
`timescale 1ns/1ps
module tb_mux32_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [7:0]  mux_data;
  logic [4:0]  sel;
  logic [31:0] ack;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef MUX_ARB_CNT_EN
  logic [15:0] grant_count;
`endif

  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;

  mux32_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mux_data  (mux_data),
    .sel       (sel),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef MUX_ARB_CNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb mux_data = mem[sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) mem[k] = 8'(k + 8'h40);
    do_reset();
    checks++;
    if (sel !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || ack !== 32'h0 || out_data !== 8'h0) begin
      errors++;
      $display("FAIL reset_values: sel=%0d valid=%b busy=%b ack=%h data=%h, want 0/0/0/0/0",
               sel, out_valid, busy, ack, out_data);
    end
`ifdef MUX_ARB_CNT_EN
    checks++;
    if (grant_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", grant_count);
    end
`endif
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (sel !== 5'd0 || out_valid !== 1'b0 || busy !== 1'b0 || ack !== 32'h0) begin
        errors++;
        $display("FAIL idle_cycle%0d: sel=%0d valid=%b busy=%b ack=%h, want 0/0/0/0",
                 c, sel, out_valid, busy, ack);
      end
    end
  endtask

  task automatic test_single();
    mem[3] = 8'hA5;
    out_ready = 1'b1;
    req = 32'h0000_0008;
    step();
    checks++;
    if (sel !== 5'd3 || out_valid !== 1'b0 || ack !== 32'h0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_sel: sel=%0d valid=%b ack=%h busy=%b, want 3/0/0/1", sel, out_valid, ack, busy);
    end
    step();
    checks++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1 || ack !== 32'h0000_0008) begin
      errors++;
      $display("FAIL single_capt: data=%h valid=%b ack=%h, want a5/1/00000008", out_data, out_valid, ack);
    end
    req = '0;
    step();
    checks++;
    if (ack !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: ack=%h valid=%b busy=%b, want 0/0/0", ack, out_valid, busy);
    end
    step();
    checks++;
    if (sel !== 5'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_quiet: sel=%0d busy=%b, want 3/0", sel, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_ack;
    do_reset();
    for (int k = 0; k < 32; k++) mem[k] = 8'(k);
    out_ready = 1'b1;
    req = 32'hFFFF_FFFF;
    for (int g = 0; g < 33; g++) begin
      exp_ack = 32'h1 << (g % 32);
      step();
      checks++;
      if (sel !== 5'(g % 32) || ack !== 32'h0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL rr_sel%0d: sel=%0d ack=%h busy=%b, want %0d/0/1", g, sel, ack, busy, g % 32);
      end
      step();
      checks++;
      if (out_data !== 8'(g % 32) || out_valid !== 1'b1 || ack !== exp_ack) begin
        errors++;
        $display("FAIL rr_capt%0d: data=%0d valid=%b ack=%h, want %0d/1/%h",
                 g, out_data, out_valid, ack, g % 32, exp_ack);
      end
`ifdef MUX_ARB_CNT_EN
      checks++;
      if (grant_count !== 16'(g + 1)) begin
        errors++;
        $display("FAIL rr_count%0d: got %0d want %0d", g, grant_count, g + 1);
      end
`endif
      step();
      checks++;
      if (out_valid !== 1'b0 || ack !== 32'h0) begin
        errors++;
        $display("FAIL rr_release%0d: valid=%b ack=%h, want 0/0", g, out_valid, ack);
      end
    end
    req = '0;
    step();
  endtask

  task automatic test_stall();
    do_reset();
    mem[5] = 8'h3C;
    out_ready = 1'b0;
    req = 32'h0000_0020;
    step();
    step();
    checks++;
    if (out_data !== 8'h3C || out_valid !== 1'b1 || ack !== 32'h0000_0020) begin
      errors++;
      $display("FAIL stall_capt: data=%h valid=%b ack=%h, want 3c/1/00000020", out_data, out_valid, ack);
    end
    req = '0;
    mem[5] = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (out_data !== 8'h3C || out_valid !== 1'b1 || ack !== 32'h0 || sel !== 5'd5 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: data=%h valid=%b ack=%h sel=%0d busy=%b, want 3c/1/0/5/1",
                 c, out_data, out_valid, ack, sel, busy);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h3C) begin
      errors++;
      $display("FAIL stall_release: valid=%b busy=%b data=%h, want 0/0/3c", out_valid, busy, out_data);
    end
  endtask

  task automatic test_wrap_pair();
    do_reset();
    out_ready = 1'b1;
    req = 32'h4000_0000;
    step();
    checks++;
    if (sel !== 5'd30) begin
      errors++;
      $display("FAIL wrap_first: sel=%0d want 30", sel);
    end
    step();
    req = '0;
    step();
    req = 32'h8000_0004;
    step();
    checks++;
    if (sel !== 5'd31) begin
      errors++;
      $display("FAIL wrap_g31: sel=%0d want 31", sel);
    end
    step();
    checks++;
    if (ack !== 32'h8000_0000) begin
      errors++;
      $display("FAIL wrap_ack31: ack=%h want 80000000", ack);
    end
    req = 32'h0000_0004;
    step();
    step();
    checks++;
    if (sel !== 5'd2) begin
      errors++;
      $display("FAIL wrap_g2: sel=%0d want 2", sel);
    end
    step();
    checks++;
    if (ack !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_ack2: ack=%h want 00000004", ack);
    end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem[7] = 8'h99;
    out_ready = 1'b0;
    req = 32'h0000_0080;
    step();
    step();
    req = '0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h99) begin
      errors++;
      $display("FAIL mid_hold: valid=%b data=%h, want 1/99", out_valid, out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h0 || ack !== 32'h0 || sel !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: valid=%b data=%h ack=%h sel=%0d busy=%b, want all 0",
               out_valid, out_data, ack, sel, busy);
    end
`ifdef MUX_ARB_CNT_EN
    checks++;
    if (grant_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_count: got %0d want 0", grant_count);
    end
`endif
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (ack !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_after%0d: ack=%h valid=%b busy=%b, want 0/0/0", c, ack, out_valid, busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap_pair();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux32_rr_arbiter.md
# mux32_rr_arbiter

Round-robin arbiter and sequencer for the 32:1 × 8-bit selection mux. The block takes 32 request lines and grants one requester at a time, starting the search after the last winner. It drives the mux `sel` input and samples the mux output into a registered result. The result is presented with a valid/ready handshake, and the granted requester receives a one-hot acknowledge pulse. The block sits between the requesting sources and the downstream consumer, with the mux as its datapath.

## Interface
- `N_REQ`, default 32: number of requesters and mux inputs.
- `DATA_W`, default 8: mux data width.
- `SEL_W`, default 5: select width, equal to $clog2(N_REQ).
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input N_REQ: request per source. Held high until that source's `ack`.
- `mux_data` input DATA_W: combinational output of the 32:1 mux.
- `sel` output SEL_W: registered select to the mux.
- `ack` output N_REQ: one-hot, one-cycle grant-complete pulse.
- `out_data` output DATA_W: captured data.
- `out_valid` output 1: `out_data` valid.
- `out_ready` input 1: consumer accepts.
- `busy` output 1: high whenever the state is not IDLE.
- `grant_count` output 16: only when MUX_ARB_CNT_EN is defined.

## Operation
- Reset values: `sel`=0, `ack`=0, `out_data`=0, `out_valid`=0, `busy`=0, `grant_count`=0, `ptr`=0, state=IDLE.
- `ptr` is the next-priority index, equal to last winner + 1 mod N_REQ.
- FSM states are IDLE, CAPT and HOLD.
- IDLE:
  - If `req` is nonzero, winner = first set bit at or after `ptr`, scanning upward and wrapping from N_REQ-1 to 0.
  - `sel` <= winner; go to CAPT.
  - Otherwise stay in IDLE; `sel` keeps its value.
- CAPT (mux has settled on the registered `sel`):
  - `out_data` <= `mux_data`.
  - `out_valid` <= 1.
  - `ack[sel]` <= 1 for exactly one cycle.
  - `ptr` <= (`sel`+1) mod N_REQ; wrap 31 -> 0.
  - Go to HOLD.
  - The `req` bit is not re-checked here: a grant issued in IDLE always completes.
- HOLD:
  - `out_valid` stays high and `out_data` stays stable until `out_ready`=1 at a rising edge.
  - On that edge `out_valid` <= 0 and the state goes to IDLE.
  - `ack` is 0 in every state except the first HOLD cycle.
- Single requester: granted every round regardless of `ptr`.
- All 32 requesting: grants are issued in strict index order, rotating.
- `req` changes while in CAPT/HOLD are ignored until the next IDLE.
- `rst` asserted mid-transfer: all outputs return to reset values immediately (asynchronously). Any pending handshake is dropped with no `ack`.

## Timing
- `req` seen at edge N (IDLE) -> `sel` valid after N -> `out_data`/`out_valid`/`ack` high after N+1.
- Minimum grant period is 3 cycles (IDLE, CAPT, HOLD with `out_ready` already 1).
- `out_ready` held low stalls the block indefinitely in HOLD, with no data loss.
- A requester must drop `req` within one cycle of `ack` to avoid being regranted. The next IDLE evaluation is no earlier than the cycle after `ack`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `MUX_ARB_CNT_EN` defined:
  - Adds output `grant_count[15:0]`, incremented on every CAPT.
  - Wraps 16'hFFFF -> 0.
  - Reset to 0.
- `MUX_ARB_CNT_EN` undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, CAPT, HOLD);
  - constants N_REQ=32, SEL_W=5, DATA_W=8, CNT_W=16.
- Sub-module `rr_pick`: purely combinational rotating-priority search.
  - Inputs: `req`, `ptr`.
  - Outputs: `winner` index and `found`.
- The top level holds the FSM and all registers.

## Test plan
- Reset, then `req`=0 for 10 cycles -> `sel`=0, `out_valid`=0, `busy`=0 throughout.
- `req`=32'h0000_0008, input 3=8'hA5, `out_ready`=1 -> `sel`=3. Two edges later: `out_data`=8'hA5, `out_valid`=1, `ack`=32'h0000_0008 for one cycle.
- `req`=32'hFFFF_FFFF held, each `i[k]`=k, `out_ready`=1 -> `out_data` sequence 0,1,…,31,0 (wrap after 31), one grant every 3 cycles.
- `out_ready`=0 for 5 cycles after `out_valid` -> `out_data` stable and `out_valid` high for all 5 cycles. No new `ack`; `sel` unchanged.
- Last grant was 30, then `req` has bits 2 and 31 set -> next grant 31, then 2.
- `rst` pulsed while in HOLD -> `out_valid`=0 and `out_data`=0 immediately, no `ack`. With MUX_ARB_CNT_EN, `grant_count`=0.
